// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory controller.
// Access size encoding, controller state and lane-enable / data-steering functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } dmem_state_t;

    localparam int unsigned LANES = 4;

    function automatic logic [3:0] be_from_size(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            MEM_BYTE: be = 4'b0001 << addr_lo;
            MEM_HALF: be = 4'b0011 << addr_lo;
            MEM_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is right-justified; replicate it so every enabled lane sees its byte.
    function automatic logic [31:0] replicate_store(input logic [1:0] size,
                                                    input logic [31:0] data);
        logic [31:0] lanes;
        lanes = data;
        case (size)
            MEM_BYTE: lanes = {4{data[7:0]}};
            MEM_HALF: lanes = {2{data[15:0]}};
            default:  lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] extend_load(input logic [1:0] size,
                                                input logic sgn,
                                                input logic [31:0] data);
        logic [31:0] ext;
        ext = data;
        case (size)
            MEM_BYTE: ext = {{24{sgn & data[7]}}, data[7:0]};
            MEM_HALF: ext = {{16{sgn & data[15]}}, data[15:0]};
            default:  ext = data;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// One 8-bit memory lane: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_lane #(
    parameter int unsigned DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Size-aware data memory controller: valid/ready request, IDLE->WAIT->ACCESS->RESP FSM,
// alignment/range checking and sign/zero-extended loads over four byte lanes.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        access;
    logic [29:0] word_off;
    logic [AW-1:0] idx;
    logic        range_err;
    logic        align_err;
    logic        acc_err;
    logic [3:0]  be;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [31:0] rd_word;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (WAIT_STATES != 0) ? StWait : StAccess;
                end
            end
            StWait: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAccess: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        access    = 1'b0;
        case (state_q)
            StIdle:   req_ready = 1'b1;
            StAccess: access    = 1'b1;
            StResp:   rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- Request capture ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (req_ready && req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // ---------------- Decode and checks ----------------
    // BASE_ADDR is word aligned, so the word offset is a 30-bit subtraction.
    assign word_off  = addr_q[31:2] - BASE_ADDR[31:2];
    assign idx       = word_off[AW-1:0];
    assign range_err = (addr_q[31:2] < BASE_ADDR[31:2]) || (word_off >= 30'(DEPTH));

    always_comb begin
        align_err = 1'b0;
        case (size_q)
            MEM_BYTE: align_err = 1'b0;
            MEM_HALF: align_err = addr_q[0];
            MEM_WORD: align_err = (addr_q[1:0] != 2'b00);
            default:  align_err = 1'b1;
        endcase
    end

    assign acc_err    = range_err | align_err;
    assign be         = be_from_size(size_q, addr_q[1:0]);
    assign lane_wdata = replicate_store(size_q, wdata_q);
    assign lane_we    = (access && we_q && !acc_err) ? be : 4'b0000;

    // ---------------- Memory lanes ----------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dmem_lane #(
            .DEPTH(DEPTH)
        ) u_lane (
            .clk  (clk),
            .we   (lane_we[g]),
            .addr (idx),
            .wdata(lane_wdata[8*g +: 8]),
            .rdata(rd_word[8*g +: 8])
        );
    end

    assign rd_shifted = rd_word >> {addr_q[1:0], 3'b000};
    assign load_data  = extend_load(size_q, sgn_q, rd_shifted);

    // ---------------- Response registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (access) begin
            rdata_q <= (acc_err || we_q) ? 32'h0 : load_data;
            err_q   <= acc_err;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stimulus pushes expected responses to a scoreboard,
// a negedge monitor pops and compares them and checks response latency.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned WS    = 1;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DEPTH      (DEPTH),
        .WAIT_STATES(WS),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [32:0] exp_q[$];
    string       name_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic record_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: latency from accept cycle, req_ready low in RESP, scoreboard pop.
    int   acc_cyc = 0;
    bit   pend = 1'b0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [32:0] e;
        string nm;
        if (!reset_n) begin
            pend = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                pend = 1'b1;
            end
            if (rsp_valid && !prev_valid) begin
                check("rsp_latency", pend ? 32'(cyc - acc_cyc) : 32'hFFFF_FFFF, 32'(WS + 2));
                pend = 1'b0;
            end
            if (rsp_valid) begin
                check("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got %h err %b expected no response",
                             rsp_rdata, rsp_err);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, "_rdata"}, rsp_rdata, e[31:0]);
                    check({nm, "_err"}, {31'b0, rsp_err}, {31'b0, e[32]});
                end
            end
            prev_valid = rsp_valid;
        end
    end

    // Called and returns at posedge+1; holds req_valid until the controller accepts.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input string nm);
        bit done;
        done = 1'b0;
        exp_q.push_back({exp_err, exp_rd});
        name_q.push_back(nm);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!done) begin
            record_timeout({nm, "_accept"});
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            record_timeout("drain");
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // 1 Reset values
        repeat (2) @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 2 Word store / load
        issue(1'b1, MEM_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_w10");
        issue(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld_w10");
        drain();

        // 3 Byte/half lanes and extension
        issue(1'b1, MEM_WORD, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0, "st_w10b");
        issue(1'b1, MEM_BYTE, 1'b0, 32'h13, 32'h0000_0080, 32'h0, 1'b0, "st_b13");
        issue(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, 32'h8022_3344, 1'b0, "ld_w10_merge");
        issue(1'b0, MEM_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, "ld_b13_s");
        issue(1'b0, MEM_BYTE, 1'b0, 32'h13, 32'h0, 32'h0000_0080, 1'b0, "ld_b13_u");
        issue(1'b0, MEM_HALF, 1'b1, 32'h12, 32'h0, 32'hFFFF_8022, 1'b0, "ld_h12_s");
        issue(1'b0, MEM_HALF, 1'b0, 32'h10, 32'h0, 32'h0000_3344, 1'b0, "ld_h10_u");
        issue(1'b0, MEM_BYTE, 1'b1, 32'h11, 32'h0, 32'h0000_0033, 1'b0, "ld_b11_s");
        issue(1'b1, MEM_HALF, 1'b0, 32'h12, 32'h0000_A5B6, 32'h0, 1'b0, "st_h12");
        issue(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, 32'hA5B6_3344, 1'b0, "ld_w10_half");
        issue(1'b1, MEM_BYTE, 1'b0, 32'h7FF, 32'h0000_007F, 32'h0, 1'b0, "st_b_last");
        issue(1'b0, MEM_BYTE, 1'b0, 32'h7FF, 32'h0, 32'h0000_007F, 1'b0, "ld_b_last");
        drain();

        // 4 Errors leave memory untouched
        issue(1'b1, MEM_WORD, 1'b0, 32'h0, 32'h55AA_55AA, 32'h0, 1'b0, "st_w0");
        issue(1'b0, MEM_HALF, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "ld_h11_misal");
        issue(1'b1, MEM_WORD, 1'b0, DEPTH * 4, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_w_range");
        issue(1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0, 32'h55AA_55AA, 1'b0, "ld_w0_after_range");
        issue(1'b1, MEM_WORD, 1'b0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_w12_misal");
        issue(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, 32'hA5B6_3344, 1'b0, "ld_w10_after_misal");
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "ld_rsvd_size");
        drain();

        // 5 Backpressure, then back-to-back requests
        rsp_ready = 1'b0;
        issue(1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0, 32'h55AA_55AA, 1'b0, "bp_ld_w0");
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        if (!seen) record_timeout("bp_rsp_valid");
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid_held", {31'b0, rsp_valid}, 32'h1);
            check("bp_rsp_rdata_held", rsp_rdata, 32'h55AA_55AA);
            check("bp_req_ready_low", {31'b0, req_ready}, 32'h0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        issue(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, 32'hA5B6_3344, 1'b0, "b2b_ld_w10");
        issue(1'b0, MEM_BYTE, 1'b1, 32'h12, 32'h0, 32'hFFFF_FFB6, 1'b0, "b2b_ld_b12_s");
        drain();

        // 6 Reset while a store waits: store must never land
        issue(1'b1, MEM_WORD, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0, "st_w20");
        drain();
        issue(1'b1, MEM_WORD, 1'b0, 32'h20, 32'hCAFE_BABE, 32'h0, 1'b0, "rst_st_w20");
        reset_n = 1'b0;
        exp_q.delete();
        name_q.delete();
        @(negedge clk);
        check("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("postrst_req_ready", {31'b0, req_ready}, 32'h1);
        check("postrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        issue(1'b0, MEM_WORD, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, "ld_w20_old");
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
